// File: rtl/estagio_wb_pkg.sv
// Shared definitions for the write-back stage of the 16-bit pipeline.
// Contents:
//   LARGURA, NREG_BITS : default datapath and register-index widths
//   sel_wb_t           : write-back data source (ALU result or memory word)
//   ctrl_wb_t          : write-back control carried by the stage register
package estagio_wb_pkg;

  localparam int LARGURA   = 16;
  localparam int NREG_BITS = 3;

  typedef enum logic {
    SEL_ULA = 1'b0,
    SEL_MEM = 1'b1
  } sel_wb_t;

  typedef struct packed {
    logic                 valido;
    logic                 hab_escrita;
    sel_wb_t              sel;
    logic [NREG_BITS-1:0] reg_destino;
  } ctrl_wb_t;

endpackage

// File: rtl/estagio_wb_if.sv
// Bus between the execute/memory stage, the write-back stage and the
// register bank / forwarding logic.
//   master : the environment (execute/memory stage + register bank side)
//   slave  : the write-back stage itself
// Flow semantics: there is no back-pressure on this bus. valido_in marks a
// real instruction offered by execute/memory and is taken at every rising
// edge unless stall holds the stage; valido_out marks that the stage holds a
// real instruction. Only BR_Hab_Escrita commits a register-bank write.
interface estagio_wb_if #(
  parameter int LARGURA   = 16,
  parameter int NREG_BITS = 3
);
  // execute/memory -> write-back
  logic                 valido_in;
  logic [LARGURA-1:0]   Saida_ULA;
  logic [LARGURA-1:0]   Saida_MemoriaDados;
  logic                 BR_Hab_Escrita_in;
  logic                 controleMUX_WB;
  logic [NREG_BITS-1:0] reg_destino_in;
  // write-back -> register bank / forwarding
  logic                 BR_Hab_Escrita;
  logic [NREG_BITS-1:0] BR_endereco;
  logic [LARGURA-1:0]   Saida_WB;
  logic                 valido_out;
  logic                 fwd_valido;
  logic [NREG_BITS-1:0] fwd_reg;
  logic [LARGURA-1:0]   fwd_dado;

  modport master (
    output valido_in, Saida_ULA, Saida_MemoriaDados, BR_Hab_Escrita_in,
           controleMUX_WB, reg_destino_in,
    input  BR_Hab_Escrita, BR_endereco, Saida_WB, valido_out,
           fwd_valido, fwd_reg, fwd_dado
  );

  modport slave (
    input  valido_in, Saida_ULA, Saida_MemoriaDados, BR_Hab_Escrita_in,
           controleMUX_WB, reg_destino_in,
    output BR_Hab_Escrita, BR_endereco, Saida_WB, valido_out,
           fwd_valido, fwd_reg, fwd_dado
  );
endinterface

// File: rtl/estagio_wb_mux.sv
// 2:1 LARGURA-wide selector for the write-back data source, same style as
// the ALU-input selector.
//   sel   : SEL_ULA picks a_ula, SEL_MEM picks b_mem
//   a_ula : registered ALU result
//   b_mem : memory word (live or held)
//   y     : selected word
module estagio_wb_mux #(
  parameter int LARGURA = 16
) (
  input  estagio_wb_pkg::sel_wb_t sel,
  input  logic [LARGURA-1:0]      a_ula,
  input  logic [LARGURA-1:0]      b_mem,
  output logic [LARGURA-1:0]      y
);
  import estagio_wb_pkg::*;

  assign y = (sel == SEL_MEM) ? b_mem : a_ula;
endmodule

// File: rtl/estagio_wb.sv
// Write-back stage of the 16-bit pipeline.
// Registers the ALU result and write-back control from execute/memory, pairs
// the registered ALU result with the synchronous-memory read word (which
// arrives one cycle after capture), selects one and drives the register-bank
// write port plus a forwarding bus back to execute.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   stall          : hold stage contents and suppress the write
//   flush          : load a bubble at the next edge (wins over stall)
//   wb             : estagio_wb_if.slave bus (inputs from execute/memory,
//                    register-bank write port and forwarding outputs)
//   contador_instr : retired-instruction counter, present only when the
//                    macro CONTADOR_INSTR_EN is defined
module estagio_wb #(
  parameter int LARGURA   = 16,
  parameter int NREG_BITS = 3,
  parameter bit R0_FIXO   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  estagio_wb_if.slave wb
`ifdef CONTADOR_INSTR_EN
  ,
  output logic [31:0] contador_instr
`endif
);
  import estagio_wb_pkg::*;

  ctrl_wb_t           ctrl_q;
  ctrl_wb_t           ctrl_in;
  logic [LARGURA-1:0] ula_q;
  logic [LARGURA-1:0] mem_hold_q;   // memory word saved on the first stall edge
  logic               hold_q;       // mem_hold_q replaces the live memory input
  logic               stall_ant_q;  // stall seen at the previous edge

  logic [LARGURA-1:0] mem_dado;
  logic [LARGURA-1:0] saida_wb;
  logic               r0_bloq;
  logic               escreve;

  always_comb begin
    ctrl_in             = '0;
    ctrl_in.valido      = wb.valido_in;
    ctrl_in.hab_escrita = wb.BR_Hab_Escrita_in;
    ctrl_in.sel         = sel_wb_t'(wb.controleMUX_WB);
    ctrl_in.reg_destino = wb.reg_destino_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      ula_q       <= '0;
      mem_hold_q  <= '0;
      hold_q      <= 1'b0;
      stall_ant_q <= 1'b0;
    end else begin
      stall_ant_q <= stall;
      if (flush) begin
        ctrl_q.valido      <= 1'b0;
        ctrl_q.hab_escrita <= 1'b0;
        hold_q             <= 1'b0;
      end else if (stall) begin
        // The memory word is only live during the cycle right after capture,
        // so the first stalled edge is the last chance to keep it.
        if (!stall_ant_q) begin
          mem_hold_q <= wb.Saida_MemoriaDados;
          hold_q     <= 1'b1;
        end
      end else begin
        ctrl_q <= ctrl_in;
        ula_q  <= wb.Saida_ULA;
        hold_q <= 1'b0;
      end
    end
  end

  assign mem_dado = hold_q ? mem_hold_q : wb.Saida_MemoriaDados;

  estagio_wb_mux #(.LARGURA(LARGURA)) u_mux (
    .sel   (ctrl_q.sel),
    .a_ula (ula_q),
    .b_mem (mem_dado),
    .y     (saida_wb)
  );

  assign r0_bloq = R0_FIXO && (ctrl_q.reg_destino == '0);
  assign escreve = ctrl_q.valido & ctrl_q.hab_escrita & ~r0_bloq;

  // Forwarding stays valid while stalled: the value is still the one that
  // will be written when the stall releases.
  assign wb.BR_Hab_Escrita = escreve & ~stall;
  assign wb.BR_endereco    = ctrl_q.reg_destino;
  assign wb.Saida_WB       = saida_wb;
  assign wb.valido_out     = ctrl_q.valido;
  assign wb.fwd_valido     = escreve;
  assign wb.fwd_reg        = ctrl_q.reg_destino;
  assign wb.fwd_dado       = saida_wb;

`ifdef CONTADOR_INSTR_EN
  logic [31:0] contador_q;

  // Counts instructions leaving the stage; wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_q <= '0;
    end else if (ctrl_q.valido && !stall && !flush) begin
      contador_q <= contador_q + 32'd1;
    end
  end

  assign contador_instr = contador_q;
`endif

endmodule
